// File: rtl/trdb_apb_master.sv
// APB3 initiator: turns a valid/ready request into a single APB transfer and
// returns read data / error on a valid/ready response channel, with a watchdog.
module trdb_apb_master #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic                      req_we_i,
    input  logic [31:0]               req_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic [31:0]               pwdata,
    output logic                      pwrite,
    output logic                      psel,
    output logic                      penable,
    input  logic [31:0]               prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wdog_cnt;

    // All outputs are registered alongside the state, so APB strobes never
    // depend combinationally on pready/pslverr or on req_valid_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pwrite      <= 1'b0;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            wdog_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_ready_o && req_valid_i) begin
                        paddr       <= req_addr_i;
                        pwrite      <= req_we_i;
                        pwdata      <= req_wdata_i;
                        wdog_cnt    <= '0;
                        psel        <= 1'b1;
                        req_ready_o <= 1'b0;
                        state       <= SETUP;
                    end else begin
                        req_ready_o <= 1'b1;
                    end
                end

                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    // A late pready beats the watchdog when both land together.
                    if (pready) begin
                        rsp_err_o   <= pslverr;
                        rsp_rdata_o <= (pwrite || pslverr) ? 32'h0 : prdata;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else if (WDOG_EN && (wdog_cnt == CNT_LAST)) begin
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= 32'h0;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else if (wdog_cnt != CNT_MAX) begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
                end

                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        wdog_cnt    <= '0;
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trdb_apb_master.sv
// Directed bench for trdb_apb_master: a table of APB transfers with hand-computed
// responses, plus sequences for backpressure and mid-transfer reset.
module tb_trdb_apb_master;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_we;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;

    int assert_count = 0;
    int fail_count   = 0;

    typedef struct {
        string         name;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        int            waits;
        logic          slverr;
        logic [31:0]   rdata_in;
        int            exp_access;
        logic          exp_err;
        logic [31:0]   exp_rdata;
    } vec_t;

    vec_t vecs[8];

    trdb_apb_master #(
        .APB_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_addr_i (req_addr),
        .req_we_i   (req_we),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o  (rsp_err),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pwrite     (pwrite),
        .psel       (psel),
        .penable    (penable),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got hang, expected completion");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Waits until the DUT is ready, presents the request, and returns at the
    // negedge of the SETUP cycle with req_valid dropped.
    task automatic issueRequest(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata);
        int budget;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        budget    = 0;
        while (req_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20) checkOutput("accept_timeout", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        issueRequest(v.we, v.addr, v.wdata);
        checkOutput({v.name, "_setup_psel"},    {31'h0, psel},      32'h1);
        checkOutput({v.name, "_setup_penable"}, {31'h0, penable},   32'h0);
        checkOutput({v.name, "_setup_ready"},   {31'h0, req_ready}, 32'h0);
        checkOutput({v.name, "_paddr"},         {20'h0, paddr},     {20'h0, v.addr});
        checkOutput({v.name, "_pwrite"},        {31'h0, pwrite},    {31'h0, v.we});
        checkOutput({v.name, "_pwdata"},        pwdata,             v.wdata);
        for (int i = 0; i < v.exp_access; i++) begin
            @(negedge clk);
            checkOutput({v.name, "_acc_psel"},    {31'h0, psel},      32'h1);
            checkOutput({v.name, "_acc_penable"}, {31'h0, penable},   32'h1);
            checkOutput({v.name, "_acc_rsp"},     {31'h0, rsp_valid}, 32'h0);
            checkOutput({v.name, "_acc_paddr"},   {20'h0, paddr},     {20'h0, v.addr});
            checkOutput({v.name, "_acc_pwdata"},  pwdata,             v.wdata);
            // Garbage on prdata/pslverr while not ready must be ignored.
            pready  = (i == v.waits);
            prdata  = (i == v.waits) ? v.rdata_in : ~v.rdata_in;
            pslverr = (i == v.waits) ? v.slverr : 1'b1;
        end
        @(negedge clk);
        pready  = 1'b0;
        pslverr = 1'b0;
        checkOutput({v.name, "_rsp_valid"},   {31'h0, rsp_valid}, 32'h1);
        checkOutput({v.name, "_rsp_psel"},    {31'h0, psel},      32'h0);
        checkOutput({v.name, "_rsp_penable"}, {31'h0, penable},   32'h0);
        checkOutput({v.name, "_rsp_err"},     {31'h0, rsp_err},   {31'h0, v.exp_err});
        checkOutput({v.name, "_rsp_rdata"},   rsp_rdata,          v.exp_rdata);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput({v.name, "_done_valid"}, {31'h0, rsp_valid}, 32'h0);
        checkOutput({v.name, "_done_ready"}, {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        vecs[0] = '{"wr_zero_wait",  1'b1, 12'h004, 32'hDEADBEEF, 0,   1'b0, 32'h0,        1, 1'b0, 32'h0};
        vecs[1] = '{"rd_three_wait", 1'b0, 12'h010, 32'h0,        3,   1'b0, 32'h12345678, 4, 1'b0, 32'h12345678};
        vecs[2] = '{"rd_slverr",     1'b0, 12'h020, 32'h0,        0,   1'b1, 32'hFFFFFFFF, 1, 1'b1, 32'h0};
        vecs[3] = '{"rd_timeout",    1'b0, 12'h030, 32'h0,        255, 1'b0, 32'h0,        8, 1'b1, 32'h0};
        vecs[4] = '{"rd_ready_8th",  1'b0, 12'h034, 32'h0,        7,   1'b0, 32'hA5A50001, 8, 1'b0, 32'hA5A50001};
        vecs[5] = '{"wr_slverr",     1'b1, 12'h040, 32'h01020304, 2,   1'b1, 32'h77777777, 3, 1'b1, 32'h0};
        vecs[6] = '{"wr_timeout",    1'b1, 12'h044, 32'hCAFEF00D, 255, 1'b0, 32'h0,        8, 1'b1, 32'h0};
        vecs[7] = '{"rd_top_addr",   1'b0, 12'hFFC, 32'h0,        1,   1'b0, 32'h0BADF00D, 2, 1'b0, 32'h0BADF00D};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_we    = 1'b0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        // Reset values before any clock edge.
        #3;
        checkOutput("rst_psel",      {31'h0, psel},      32'h0);
        checkOutput("rst_penable",   {31'h0, penable},   32'h0);
        checkOutput("rst_req_ready", {31'h0, req_ready}, 32'h0);
        checkOutput("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("rst_rsp_rdata", rsp_rdata,          32'h0);
        checkOutput("rst_paddr",     {20'h0, paddr},     32'h0);
        checkOutput("rst_pwdata",    pwdata,             32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ready", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Response backpressure with a second request waiting.
        issueRequest(1'b0, 12'h050, 32'h0);
        @(negedge clk);
        pready = 1'b1;
        prdata = 32'h55AA55AA;
        @(negedge clk);
        pready    = 1'b0;
        prdata    = 32'h0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 12'h060;
        req_wdata = 32'h11112222;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            checkOutput("bp_rsp_rdata", rsp_rdata,          32'h55AA55AA);
            checkOutput("bp_rsp_err",   {31'h0, rsp_err},   32'h0);
            checkOutput("bp_req_ready", {31'h0, req_ready}, 32'h0);
            checkOutput("bp_paddr",     {20'h0, paddr},     32'h050);
            @(negedge clk);
        end
        checkOutput("bp_still_valid", {31'h0, rsp_valid}, 32'h1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("bp_idle_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("bp_idle_ready", {31'h0, req_ready}, 32'h1);
        checkOutput("bp_idle_psel",  {31'h0, psel},      32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("bp2_psel",   {31'h0, psel},  32'h1);
        checkOutput("bp2_paddr",  {20'h0, paddr}, 32'h060);
        checkOutput("bp2_pwrite", {31'h0, pwrite}, 32'h1);
        checkOutput("bp2_pwdata", pwdata,          32'h11112222);
        @(negedge clk);
        pready = 1'b1;
        @(negedge clk);
        pready = 1'b0;
        checkOutput("bp2_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        checkOutput("bp2_rsp_rdata", rsp_rdata,          32'h0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset pulse in the middle of ACCESS.
        issueRequest(1'b0, 12'h070, 32'h0);
        @(negedge clk);
        checkOutput("mr_access_penable", {31'h0, penable}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mr_psel",      {31'h0, psel},      32'h0);
        checkOutput("mr_penable",   {31'h0, penable},   32'h0);
        checkOutput("mr_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("mr_req_ready", {31'h0, req_ready}, 32'h0);
        checkOutput("mr_paddr",     {20'h0, paddr},     32'h0);
        pready = 1'b1;
        prdata = 32'h0000CAFE;
        @(negedge clk);
        rst_n  = 1'b1;
        pready = 1'b0;
        @(negedge clk);
        checkOutput("mr_release_ready", {31'h0, req_ready}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("mr_no_rsp",  {31'h0, rsp_valid}, 32'h0);
            checkOutput("mr_no_psel", {31'h0, psel},      32'h0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/trdb_apb_master.md
Name: trdb_apb_master

Overview:
- APB3 initiator that converts a simple valid/ready request interface (addr, we, wdata) into APB transfers and returns read data and error status on a valid/ready response interface.
- Lets tracer-side logic (config readback, self-test, DMA-style register pokes) drive an APB bus toward peripherals. It is the counterpart of the APB-to-peripheral target translator.
- Handles one outstanding transfer at a time.
- A programmable watchdog aborts transfers whose target never asserts pready.

Parameters:
APB_ADDR_WIDTH, 12, width of paddr and req_addr_i
TIMEOUT_CYCLES, 256, max ACCESS-phase cycles without pready before abort; 0 disables the watchdog

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
req_valid_i  input  1  request valid
req_ready_o  output  1  request accepted when valid&ready
req_addr_i  input  APB_ADDR_WIDTH  request address
req_we_i  input  1  1=write, 0=read
req_wdata_i  input  32  write data
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response consumed when valid&ready
rsp_rdata_o  output  32  read data; 0 for writes and errors
rsp_err_o  output  1  pslverr or timeout
paddr  output  APB_ADDR_WIDTH  APB address
pwdata  output  32  APB write data
pwrite  output  1  APB direction
psel  output  1  APB select
penable  output  1  APB access phase
prdata  input  32  APB read data
pready  input  1  APB ready
pslverr  input  1  APB error

Behaviour:
- Reset (async, rst_ni=0) clears the following immediately, independent of clk_i:
  - state=IDLE
  - psel=0, penable=0, paddr=0, pwdata=0, pwrite=0
  - req_ready_o=0 while in reset; 1 in IDLE afterwards
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0
  - watchdog counter=0
- FSM states IDLE, SETUP, ACCESS, RESP:
  - IDLE: req_ready_o=1. On req_valid_i=1, capture addr/we/wdata into paddr/pwrite/pwdata and go to SETUP.
  - SETUP: psel=1, penable=0, req_ready_o=0. Go to ACCESS unconditionally after 1 cycle.
  - ACCESS: psel=1, penable=1.
    - On pready=1: capture rsp_err_o=pslverr, rsp_rdata_o=(pwrite|pslverr)?0:prdata, go to RESP.
    - On pready=0: increment the counter.
    - If TIMEOUT_CYCLES!=0, pready=0 and counter==TIMEOUT_CYCLES-1: rsp_err_o=1, rsp_rdata_o=0, go to RESP (abort).
  - RESP: psel=0, penable=0, rsp_valid_o=1. Hold rsp_* stable until rsp_ready_i=1, then go to IDLE and clear the counter.
- psel/penable are decoded from registered state only, so they are glitch-free.
- paddr/pwrite/pwdata are stable from SETUP through the end of ACCESS and retain their last value afterwards.
- rsp_valid_o=0 outside RESP.
- Latency: request accepted at edge N gives SETUP in cycle N+1 and ACCESS in N+2. Zero-wait pready gives rsp_valid_o from N+3. Each wait state adds 1 cycle.
- Throughput: with rsp_ready_i tied high, one transfer per 4 cycles (IDLE, SETUP, ACCESS, RESP).
- Counter width is max(1, $clog2(TIMEOUT_CYCLES+1)). It saturates and never wraps.
- The counter resets to 0 on entry to SETUP.
- The counter counts ACCESS cycles with pready=0. A timeout therefore fires on the TIMEOUT_CYCLES-th consecutive pready=0 cycle.
- If pready=1 arrives in the same cycle the timeout would fire, pready wins: normal completion using pslverr.
- pslverr and prdata are sampled only when psel&penable&pready. They are ignored otherwise.
- A request presented while not in IDLE is not accepted (req_ready_o=0). The requester must hold it stable until accepted.
- Reset asserted mid-SETUP/ACCESS/RESP drops psel/penable at once. Any pending response is discarded and no rsp_valid_o follows.
- No combinational paths from APB inputs to APB outputs or from req_valid_i to psel.

Test Plan:
- Write addr=0x004, wdata=0xDEADBEEF, pready=1 in first ACCESS cycle:
  - SETUP then ACCESS, each exactly 1 cycle, with paddr=0x004, pwrite=1, pwdata=0xDEADBEEF.
  - rsp_valid_o at N+3, rsp_err_o=0, rsp_rdata_o=0.
- Read addr=0x010, target holds pready=0 for 3 ACCESS cycles then pready=1 with prdata=0x12345678:
  - penable high for 4 cycles, APB signals stable throughout.
  - rsp_rdata_o=0x12345678, rsp_err_o=0, rsp_valid_o at N+6.
- Read with pready=1, pslverr=1, prdata=0xFFFFFFFF -> rsp_err_o=1, rsp_rdata_o=0.
- TIMEOUT_CYCLES=8, pready stuck 0 -> after exactly 8 ACCESS cycles psel drops, rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0.
  - Repeat with pready=1 on the 8th cycle -> normal completion, rsp_err_o=0.
- rsp_ready_i held 0 for 5 cycles with req_valid_i=1 for a second request:
  - rsp_* stable, req_ready_o=0 throughout.
  - After the handshake the second request is accepted 1 cycle later.
- rst_ni pulsed low during ACCESS -> psel=penable=0 asynchronously, rsp_valid_o never asserts, req_ready_o=1 on the first edge after release.
